// File: rtl/id_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, operand selectors, decoded record.
// Used by id_stage_pipe and id_fwd_mux.
package id_pkg;

  localparam int unsigned DataW = 32;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    SelZero,
    SelRs1,
    SelRs2,
    SelPc,
    SelImmI,
    SelImmU,
    SelImmJ
  } op_sel_e;

  typedef struct packed {
    logic [31:0]      inst;
    logic [DataW-1:0] pc;
    logic [DataW-1:0] op1;
    logic [DataW-1:0] op2;
    logic             we;
    logic [4:0]       waddr;
    logic             is_load;
  } id_dec_t;

  function automatic logic [DataW-1:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [DataW-1:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

  function automatic logic [DataW-1:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Operand source selection for one register read: priority search over forwarding
// sources (index 0 wins), regfile fallback, x0 reads zero, hazard when the winner is not ready.
module id_fwd_mux
  import id_pkg::*;
#(
  parameter int unsigned XLEN    = DataW,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic                    re_i,
  input  logic [4:0]              raddr_i,
  input  logic [XLEN-1:0]         rf_rdata_i,
  input  logic [NUM_FWD-1:0]      fwd_we_i,
  input  logic [5*NUM_FWD-1:0]    fwd_waddr_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]      fwd_rdy_i,
  output logic [XLEN-1:0]         data_o,
  output logic                    hazard_o
);

  logic            hit;
  logic            hit_rdy;
  logic [XLEN-1:0] hit_data;

  // Walk from oldest to youngest so the lowest matching index is the last one written.
  always_comb begin
    hit      = 1'b0;
    hit_rdy  = 1'b0;
    hit_data = '0;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (fwd_we_i[i] && (fwd_waddr_i[5*i +: 5] == raddr_i)) begin
        hit      = 1'b1;
        hit_rdy  = fwd_rdy_i[i];
        hit_data = fwd_wdata_i[XLEN*i +: XLEN];
      end
    end
  end

  always_comb begin
    data_o   = rf_rdata_i;
    hazard_o = 1'b0;
    if (!re_i || (raddr_i == 5'd0)) begin
      data_o = '0;
    end else if (hit) begin
      if (hit_rdy) begin
        data_o = hit_data;
      end else begin
        hazard_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage with forwarding, load-use interlock and valid/ready on both sides.
// Define ID_PERF_CNT_EN to add stall_cycles_o / issue_cnt_o saturating counters.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned XLEN     = DataW,
  parameter int unsigned NUM_FWD  = 2,
  parameter logic [31:0] NOP_INST = NOP
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             inst_i,
  input  logic [XLEN-1:0]         inst_addr_i,
  output logic [4:0]              reg1_raddr_o,
  output logic [4:0]              reg2_raddr_o,
  output logic                    reg1_re_o,
  output logic                    reg2_re_o,
  input  logic [XLEN-1:0]         reg1_rdata_i,
  input  logic [XLEN-1:0]         reg2_rdata_i,
  input  logic [NUM_FWD-1:0]      fwd_we_i,
  input  logic [5*NUM_FWD-1:0]    fwd_waddr_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]      fwd_rdy_i,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [31:0]             inst_o,
  output logic [XLEN-1:0]         inst_addr_o,
  output logic [XLEN-1:0]         op1_o,
  output logic [XLEN-1:0]         op2_o,
  output logic                    reg_we_o,
  output logic [4:0]              reg_waddr_o,
  output logic                    is_load_o
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]             stall_cycles_o,
  output logic [31:0]             issue_cnt_o
`endif
);

  localparam id_dec_t DecRst = '{inst: NOP_INST, default: '0};

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];

  logic    re1, re2, we_raw, load, known;
  op_sel_e sel1, sel2;

  always_comb begin
    re1    = 1'b0;
    re2    = 1'b0;
    we_raw = 1'b0;
    load   = 1'b0;
    known  = 1'b1;
    sel1   = SelZero;
    sel2   = SelZero;
    case (opcode)
      OP_IMM: begin re1 = 1'b1; we_raw = 1'b1; sel1 = SelRs1; sel2 = SelImmI; end
      OP:     begin re1 = 1'b1; re2 = 1'b1; we_raw = 1'b1; sel1 = SelRs1; sel2 = SelRs2; end
      LUI:    begin we_raw = 1'b1; sel1 = SelImmU; end
      AUIPC:  begin we_raw = 1'b1; sel1 = SelPc; sel2 = SelImmU; end
      STORE:  begin re1 = 1'b1; re2 = 1'b1; sel1 = SelRs1; sel2 = SelRs2; end
      LOAD:   begin re1 = 1'b1; we_raw = 1'b1; load = 1'b1; sel1 = SelRs1; end
      JAL:    begin we_raw = 1'b1; sel1 = SelPc; sel2 = SelImmJ; end
      JALR:   begin re1 = 1'b1; we_raw = 1'b1; sel1 = SelRs1; sel2 = SelImmI; end
      BRANCH: begin re1 = 1'b1; re2 = 1'b1; sel1 = SelRs1; sel2 = SelRs2; end
      default: known = 1'b0;
    endcase
  end

  assign reg1_re_o    = re1;
  assign reg2_re_o    = re2;
  assign reg1_raddr_o = re1 ? rs1 : 5'd0;
  assign reg2_raddr_o = re2 ? rs2 : 5'd0;

  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            haz1, haz2;

  id_fwd_mux #(
    .XLEN    (XLEN),
    .NUM_FWD (NUM_FWD)
  ) u_fwd_rs1 (
    .re_i        (re1),
    .raddr_i     (rs1),
    .rf_rdata_i  (reg1_rdata_i),
    .fwd_we_i    (fwd_we_i),
    .fwd_waddr_i (fwd_waddr_i),
    .fwd_wdata_i (fwd_wdata_i),
    .fwd_rdy_i   (fwd_rdy_i),
    .data_o      (rs1_val),
    .hazard_o    (haz1)
  );

  id_fwd_mux #(
    .XLEN    (XLEN),
    .NUM_FWD (NUM_FWD)
  ) u_fwd_rs2 (
    .re_i        (re2),
    .raddr_i     (rs2),
    .rf_rdata_i  (reg2_rdata_i),
    .fwd_we_i    (fwd_we_i),
    .fwd_waddr_i (fwd_waddr_i),
    .fwd_wdata_i (fwd_wdata_i),
    .fwd_rdy_i   (fwd_rdy_i),
    .data_o      (rs2_val),
    .hazard_o    (haz2)
  );

  function automatic logic [XLEN-1:0] op_val(input op_sel_e s, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc,
                                             input logic [31:0] inst);
    case (s)
      SelRs1:  return a;
      SelRs2:  return b;
      SelPc:   return pc;
      SelImmI: return imm_i(inst);
      SelImmU: return imm_u(inst);
      SelImmJ: return imm_j(inst);
      default: return '0;
    endcase
  endfunction

  id_dec_t dec_d, dec_q;
  logic    valid_q;

  always_comb begin
    dec_d         = '0;
    dec_d.inst    = known ? inst_i : NOP_INST;
    dec_d.pc      = inst_addr_i;
    dec_d.op1     = op_val(sel1, rs1_val, rs2_val, inst_addr_i, inst_i);
    dec_d.op2     = op_val(sel2, rs1_val, rs2_val, inst_addr_i, inst_i);
    dec_d.we      = we_raw && (rd != 5'd0);
    dec_d.waddr   = we_raw ? rd : 5'd0;
    dec_d.is_load = load;
  end

  logic hazard, accept;

  assign hazard     = in_valid_i & (haz1 | haz2);
  assign in_ready_o = ~hazard & ~flush_i & (~valid_q | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;

  // Flush already blocks accept through in_ready_o; it only needs to kill the held entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      dec_q   <= DecRst;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      dec_q   <= dec_d;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign inst_o      = dec_q.inst;
  assign inst_addr_o = dec_q.pc;
  assign op1_o       = dec_q.op1;
  assign op2_o       = dec_q.op2;
  assign reg_we_o    = dec_q.we;
  assign reg_waddr_o = dec_q.waddr;
  assign is_load_o   = dec_q.is_load;

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_q, issue_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_q <= '0;
      issue_q <= '0;
    end else begin
      if (hazard && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (accept && (issue_q != '1)) issue_q <= issue_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
  assign issue_cnt_o    = issue_q;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe (default build, perf counters absent).
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] inst, inst_addr;
  logic [4:0]  r1_addr, r2_addr;
  logic        r1_re, r2_re;
  logic [31:0] r1_data, r2_data;
  logic [1:0]  fwd_we, fwd_rdy;
  logic [9:0]  fwd_waddr;
  logic [63:0] fwd_wdata;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] inst_o, addr_o, op1, op2;
  logic        we_o, is_load;
  logic [4:0]  waddr_o;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  // Regfile stand-in: xN reads 0x1000_000N on port 1 and 0x2000_000N on port 2.
  assign r1_data = 32'h1000_0000 | 32'(r1_addr);
  assign r2_data = 32'h2000_0000 | 32'(r2_addr);

  id_stage_pipe dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .inst_i       (inst),
    .inst_addr_i  (inst_addr),
    .reg1_raddr_o (r1_addr),
    .reg2_raddr_o (r2_addr),
    .reg1_re_o    (r1_re),
    .reg2_re_o    (r2_re),
    .reg1_rdata_i (r1_data),
    .reg2_rdata_i (r2_data),
    .fwd_we_i     (fwd_we),
    .fwd_waddr_i  (fwd_waddr),
    .fwd_wdata_i  (fwd_wdata),
    .fwd_rdy_i    (fwd_rdy),
    .flush_i      (flush),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .inst_o       (inst_o),
    .inst_addr_o  (addr_o),
    .op1_o        (op1),
    .op2_o        (op2),
    .reg_we_o     (we_o),
    .reg_waddr_o  (waddr_o),
    .is_load_o    (is_load)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    inst      = 32'h0000_0013;
    inst_addr = 32'h0;
    fwd_we    = 2'b00;
    fwd_rdy   = 2'b00;
    fwd_waddr = 10'd0;
    fwd_wdata = 64'd0;
    flush     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #12;
    n_total++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid);
    end
    n_total++;
    if (inst_o !== 32'h0000_0013) begin
      n_bad++; $display("FAIL reset_inst got=%h exp=00000013", inst_o);
    end
    n_total++;
    if ({op1, op2, addr_o} !== 96'd0) begin
      n_bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", op1, op2, addr_o);
    end
    n_total++;
    if ({we_o, waddr_o, is_load} !== 7'd0) begin
      n_bad++; $display("FAIL reset_ctrl got=%b/%0d/%b exp=0", we_o, waddr_o, is_load);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    in_valid  = 1'b1;
    inst      = 32'h0050_0093;
    inst_addr = 32'h100;
    #1;
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL addi_ready got=%0b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, op1, op2, we_o, waddr_o} !== {1'b1, 32'd0, 32'd5, 1'b1, 5'd1}) begin
      n_bad++;
      $display("FAIL addi_out got v=%0b op1=%h op2=%h we=%0b rd=%0d exp v=1 op1=0 op2=5 we=1 rd=1",
               out_valid, op1, op2, we_o, waddr_o);
    end
    n_total++;
    if ({inst_o, addr_o} !== {32'h0050_0093, 32'h100}) begin
      n_bad++; $display("FAIL addi_inst got=%h/%h exp=00500093/100", inst_o, addr_o);
    end
    tick();
  endtask

  task automatic test_decode();
    logic [31:0] ti [8] = '{32'h1234_52B7, 32'h0000_1317, 32'h0081_2383, 32'h0031_2223,
                            32'hFFF0_8093, 32'h0080_00EF, 32'h0000_8067, 32'h0020_8863};
    logic [31:0] tp [8] = '{32'h10, 32'h200, 32'h14, 32'h18, 32'h1C, 32'h300, 32'h20, 32'h24};
    logic [31:0] e1 [8] = '{32'h1234_5000, 32'h200, 32'h1000_0002, 32'h1000_0002,
                            32'h1000_0001, 32'h300, 32'h1000_0001, 32'h1000_0001};
    logic [31:0] e2 [8] = '{32'h0, 32'h1000, 32'h0, 32'h2000_0003,
                            32'hFFFF_FFFF, 32'h8, 32'h0, 32'h2000_0002};
    logic        ew [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0]  ea [8] = '{5'd5, 5'd6, 5'd7, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0};
    logic        el [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      inst      = ti[i];
      inst_addr = tp[i];
      #1;
      n_total++;
      if (in_ready !== 1'b1) begin
        n_bad++; $display("FAIL dec%0d_ready got=%0b exp=1", i, in_ready);
      end
      tick();
      n_total++;
      if ({out_valid, inst_o, addr_o, op1, op2} !== {1'b1, ti[i], tp[i], e1[i], e2[i]}) begin
        n_bad++;
        $display("FAIL dec%0d_data got v=%0b i=%h pc=%h op1=%h op2=%h exp v=1 i=%h pc=%h %h %h",
                 i, out_valid, inst_o, addr_o, op1, op2, ti[i], tp[i], e1[i], e2[i]);
      end
      n_total++;
      if ({we_o, is_load} !== {ew[i], el[i]} || (ew[i] && waddr_o !== ea[i])) begin
        n_bad++;
        $display("FAIL dec%0d_ctrl got we=%0b rd=%0d ld=%0b exp we=%0b rd=%0d ld=%0b",
                 i, we_o, waddr_o, is_load, ew[i], ea[i], el[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_fwd_priority();
    in_valid  = 1'b1;
    inst      = 32'h0020_81B3;  // add x3,x1,x2
    fwd_we    = 2'b11;
    fwd_rdy   = 2'b11;
    fwd_waddr = {5'd1, 5'd1};
    fwd_wdata = {32'hB, 32'hA};
    tick();
    n_total++;
    if ({out_valid, op1, op2} !== {1'b1, 32'hA, 32'h2000_0002}) begin
      n_bad++; $display("FAIL fwd_young got op1=%h op2=%h exp A/20000002", op1, op2);
    end
    fwd_we = 2'b10;
    tick();
    n_total++;
    if (op1 !== 32'hB) begin
      n_bad++; $display("FAIL fwd_src1 got=%h exp=b", op1);
    end
    inst      = 32'h0020_01B3;  // add x3,x0,x2 with a source claiming x0
    fwd_we    = 2'b01;
    fwd_rdy   = 2'b00;
    fwd_waddr = {5'd0, 5'd0};
    #1;
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL fwd_x0_ready got=%0b exp=1", in_ready);
    end
    tick();
    n_total++;
    if (op1 !== 32'h0) begin
      n_bad++; $display("FAIL fwd_x0 got=%h exp=0", op1);
    end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    in_valid  = 1'b1;
    inst      = 32'h0021_8233;  // add x4,x3,x2
    fwd_we    = 2'b01;
    fwd_rdy   = 2'b00;
    fwd_waddr = {5'd0, 5'd2};
    for (int c = 0; c < 2; c++) begin
      #1;
      n_total++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL lu_stall%0d got=%0b exp=0", c, in_ready);
      end
      tick();
      n_total++;
      if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL lu_bubble%0d got=%0b exp=0", c, out_valid);
      end
    end
    fwd_rdy   = 2'b01;
    fwd_wdata = {32'h0, 32'h55};
    #1;
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL lu_release got=%0b exp=1", in_ready);
    end
    tick();
    n_total++;
    if ({out_valid, op1, op2} !== {1'b1, 32'h1000_0003, 32'h55}) begin
      n_bad++; $display("FAIL lu_data got v=%0b %h %h exp 1 10000003 55", out_valid, op1, op2);
    end
    // Disabled reads never stall: LUI rs1 field is 8, opcode 0x7F has rs1 field 1.
    fwd_rdy   = 2'b00;
    fwd_waddr = {5'd1, 5'd8};
    fwd_we    = 2'b11;
    inst      = 32'h1234_52B7;
    #1;
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL lu_noread got=%0b exp=1", in_ready);
    end
    tick();
    inst      = 32'h0000_807F;
    inst_addr = 32'h44;
    #1;
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bad_op_ready got=%0b exp=1", in_ready);
    end
    tick();
    n_total++;
    if ({out_valid, inst_o, we_o, op1, op2, addr_o} !==
        {1'b1, 32'h0000_0013, 1'b0, 32'd0, 32'd0, 32'h44}) begin
      n_bad++;
      $display("FAIL bad_op got v=%0b i=%h we=%0b %h %h pc=%h exp 1 00000013 0 0 0 44",
               out_valid, inst_o, we_o, op1, op2, addr_o);
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    inst     = 32'h0050_0093;
    tick();
    out_ready = 1'b0;
    inst      = 32'h0070_0113;  // addi x2,x0,7
    #1;
    n_total++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_ready got=%0b exp=0", in_ready);
    end
    tick();
    n_total++;
    if ({out_valid, op2, waddr_o} !== {1'b1, 32'd5, 5'd1}) begin
      n_bad++; $display("FAIL bp_hold got v=%0b op2=%h rd=%0d exp 1 5 1", out_valid, op2, waddr_o);
    end
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_ready got=%0b exp=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_total++;
    if ({out_valid, op2, waddr_o} !== {1'b1, 32'd7, 5'd2}) begin
      n_bad++; $display("FAIL b2b_issue got v=%0b op2=%h rd=%0d exp 1 7 2", out_valid, op2, waddr_o);
    end
    tick();
    n_total++;
    if ({out_valid, op2, inst_o} !== {1'b0, 32'd7, 32'h0070_0113}) begin
      n_bad++; $display("FAIL drain got v=%0b op2=%h i=%h exp 0 7 00700113", out_valid, op2, inst_o);
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    inst     = 32'h0050_0093;
    flush    = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL flush_ready got=%0b exp=0", in_ready);
    end
    tick();
    n_total++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_drop got=%0b exp=0", out_valid);
    end
    flush = 1'b0;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b1;
    tick();
    n_total++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_held got=%0b exp=0", out_valid);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    inst     = 32'h0070_0113;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, inst_o, op2, we_o} !== {1'b0, 32'h0000_0013, 32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_mid got v=%0b i=%h op2=%h we=%0b exp 0 00000013 0 0",
               out_valid, inst_o, op2, we_o);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_total++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_release got=%0b exp=0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_decode();
    test_fwd_priority();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
